// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - opcode/ALU constants, state encoding and decode helpers for the mini-SRC sequencer
package control_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;

  typedef enum logic [3:0] {
    S_T0   = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_T5   = 4'd5,
    S_HALT = 4'd6
  } state_t;

  function automatic logic is_rfmt(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_ROL);
  endfunction

  function automatic logic is_imm(input logic [4:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  // R-format ops use their own opcode as the ALU code; immediates map onto the R-format equivalent.
  function automatic logic [4:0] alu_code(input logic [4:0] op);
    logic [4:0] code;
    case (op)
      OP_ADDI: code = ALU_ADD;
      OP_ANDI: code = ALU_AND;
      OP_ORI:  code = ALU_OR;
      default: code = is_rfmt(op) ? op : ALU_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - sequencer <-> datapath strobe and instruction bundle
interface control_unit_if;
  logic [31:0] IR;
  logic        Stop;
  logic        PCout, ZLOout, MDRout, Cout;
  logic        MARin, PCin, MDRin, IRin, Yin, Zin;
  logic        IncrementPC, Read, Run;
  logic [15:0] Rin, Rout;
  logic [4:0]  ALUControl;

  modport master (
    input  IR, Stop,
    output PCout, ZLOout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, Zin,
    output IncrementPC, Read, Run, Rin, Rout, ALUControl
  );

  modport slave (
    output IR, Stop,
    input  PCout, ZLOout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, Zin,
    input  IncrementPC, Read, Run, Rin, Rout, ALUControl
  );
endinterface

// File: rtl/reg_decode_4to16.sv
// rtl/reg_decode_4to16.sv - 4-bit register field to one-hot 16 enable
module reg_decode_4to16 (
  input  logic [3:0]  field,
  input  logic        en,
  output logic [15:0] onehot
);
  assign onehot = en ? (16'd1 << field) : 16'd0;
endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired fetch/decode/execute sequencer driving mini-SRC datapath strobes
module control_unit
  import control_pkg::*;
(
  input  logic           Clock,
  input  logic           Reset,
  control_unit_if.master bus
);

  state_t state_q, state_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc, rout_field;
  logic       rin_en, rout_en;
  logic       pc_out, zlo_out, mdr_out, c_out;
  logic       mar_in, pc_in, mdr_in, ir_in, y_in, z_in;
  logic       inc_pc, rd, run;
  logic [4:0] alu_ctl;

  assign op = bus.IR[31:27];
  assign ra = bus.IR[26:23];
  assign rb = bus.IR[22:19];
  assign rc = bus.IR[18:15];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= S_T0;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_T0: state_d = S_T1;
      S_T1: state_d = S_T2;
      S_T2: begin
        if (is_rfmt(op) || is_imm(op)) state_d = S_T3;
        else if (op == OP_HALT)        state_d = S_HALT;
        else                           state_d = bus.Stop ? S_HALT : S_T0;
      end
      S_T3: state_d = S_T4;
      S_T4: state_d = S_T5;
      S_T5: state_d = bus.Stop ? S_HALT : S_T0;
      default: state_d = S_HALT;
    endcase
  end

  // Every strobe is gated by Reset so the datapath sees nothing while the sequencer is held in T0.
  always_comb begin
    pc_out  = 1'b0; zlo_out = 1'b0; mdr_out = 1'b0; c_out  = 1'b0;
    mar_in  = 1'b0; pc_in   = 1'b0; mdr_in  = 1'b0; ir_in  = 1'b0;
    y_in    = 1'b0; z_in    = 1'b0; inc_pc  = 1'b0; rd     = 1'b0;
    rin_en  = 1'b0; rout_en = 1'b0; alu_ctl = ALU_NONE;
    rout_field = rb;
    run     = !Reset && (state_q != S_HALT);
    if (!Reset) begin
      case (state_q)
        S_T0: begin
          pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
        end
        S_T1: begin
          zlo_out = 1'b1; pc_in = 1'b1; rd = 1'b1; mdr_in = 1'b1;
        end
        S_T2: begin
          mdr_out = 1'b1; ir_in = 1'b1;
        end
        S_T3: begin
          rout_en = 1'b1; y_in = 1'b1;
        end
        S_T4: begin
          rout_field = rc;
          rout_en    = is_rfmt(op);
          c_out      = is_imm(op);
          alu_ctl    = alu_code(op);
          z_in       = 1'b1;
        end
        S_T5: begin
          zlo_out = 1'b1; rin_en = 1'b1;
        end
        default: ;
      endcase
    end
  end

  reg_decode_4to16 u_rin_dec (
    .field  (ra),
    .en     (rin_en),
    .onehot (bus.Rin)
  );

  reg_decode_4to16 u_rout_dec (
    .field  (rout_field),
    .en     (rout_en),
    .onehot (bus.Rout)
  );

  assign bus.PCout       = pc_out;
  assign bus.ZLOout      = zlo_out;
  assign bus.MDRout      = mdr_out;
  assign bus.Cout        = c_out;
  assign bus.MARin       = mar_in;
  assign bus.PCin        = pc_in;
  assign bus.MDRin       = mdr_in;
  assign bus.IRin        = ir_in;
  assign bus.Yin         = y_in;
  assign bus.Zin         = z_in;
  assign bus.IncrementPC = inc_pc;
  assign bus.Read        = rd;
  assign bus.Run         = run;
  assign bus.ALUControl  = alu_ctl;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit
module tb_control_unit;

  logic Clock;
  logic Reset;
  control_unit_if bus ();

  control_unit dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.master)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic pcout, zloout, mdrout, cout, marin, pcin, mdrin, irin, yin, zin, inc, rd, run;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu;
  } exp_t;

  int    vectors     = 0;
  int    miscompares = 0;
  exp_t  exp_cur;
  logic  exp_valid   = 1'b0;
  string exp_name    = "";

  // k is the cycle index inside one instruction (0..5); negative means halted or in reset.
  function automatic exp_t model(input int k, input logic [31:0] ir);
    exp_t e;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic rf, im;
    e  = '0;
    op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    rf = (op >= 5'd3) && (op <= 5'd11);
    im = (op == 5'd12) || (op == 5'd13) || (op == 5'd14);
    if (k < 0) return e;
    e.run = 1'b1;
    case (k)
      0: begin e.pcout = 1; e.marin = 1; e.inc = 1; e.zin = 1; end
      1: begin e.zloout = 1; e.pcin = 1; e.rd = 1; e.mdrin = 1; end
      2: begin e.mdrout = 1; e.irin = 1; end
      3: begin e.rout = 16'd1 << rb; e.yin = 1; end
      4: begin
        if (rf) e.rout = 16'd1 << rc;
        else    e.cout = 1'b1;
        e.alu = rf ? op : (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6;
        e.zin = 1'b1;
      end
      default: begin e.rin = 16'd1 << ra; e.zloout = 1; end
    endcase
    return e;
  endfunction

  function automatic exp_t dut_vec();
    exp_t g;
    g = '{bus.PCout, bus.ZLOout, bus.MDRout, bus.Cout, bus.MARin, bus.PCin, bus.MDRin,
          bus.IRin, bus.Yin, bus.Zin, bus.IncrementPC, bus.Read, bus.Run,
          bus.Rin, bus.Rout, bus.ALUControl};
    return g;
  endfunction

  always @(negedge Clock) begin
    if (exp_valid) begin
      vectors++;
      if (dut_vec() !== exp_cur) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", exp_name, dut_vec(), exp_cur);
      end
    end
  end

  task automatic check_lit(input string nm, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic cycle(input int k, input logic [31:0] ir, input string nm);
    exp_cur   = model(k, ir);
    exp_name  = nm;
    exp_valid = 1'b1;
    @(negedge Clock);
    #1;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic int instr_len(input logic [31:0] ir);
    logic [4:0] op;
    op = ir[31:27];
    return ((op >= 5'd3 && op <= 5'd11) || (op >= 5'd12 && op <= 5'd14)) ? 6 : 3;
  endfunction

  task automatic run_instr(input logic [31:0] ir, input logic stop_end, input string nm);
    int n;
    n = instr_len(ir);
    bus.IR = ir;
    for (int k = 0; k < n; k++) begin
      bus.Stop = stop_end && (k == n - 1);
      cycle(k, ir, nm);
      tick();
    end
    bus.Stop = 1'b0;
  endtask

  task automatic halted(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      cycle(-1, 32'h0, nm);
      tick();
    end
  endtask

  task automatic do_reset(input int n);
    Reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      cycle(-1, 32'h0, "reset");
      check_lit("reset_all_zero", 64'(dut_vec()), 64'd0);
      tick();
    end
    Reset = 1'b0;
  endtask

  logic [31:0] ir_v;

  initial begin
    Reset    = 1'b1;
    bus.IR   = 32'h0;
    bus.Stop = 1'b0;
    do_reset(3);

    // and R1, R2, R3 with hand-computed literals
    ir_v   = 32'h28918000;
    bus.IR = ir_v;
    for (int k = 0; k < 6; k++) begin
      cycle(k, ir_v, "and_r1_r2_r3");
      if (k == 0) check_lit("first_t0", 64'({bus.PCout, bus.MARin, bus.IncrementPC, bus.Zin}), 64'hF);
      if (k == 3) check_lit("and_t3", 64'({bus.Rout, bus.Yin}), 64'({16'h0004, 1'b1}));
      if (k == 4) check_lit("and_t4", 64'({bus.Rout, bus.ALUControl}), 64'({16'h0008, 5'b00101}));
      if (k == 5) check_lit("and_t5", 64'({bus.Rin, bus.ZLOout}), 64'({16'h0002, 1'b1}));
      tick();
    end

    // addi R4, R5, C
    ir_v   = {5'b01100, 4'd4, 4'd5, 4'd7, 15'h0123};
    bus.IR = ir_v;
    for (int k = 0; k < 6; k++) begin
      cycle(k, ir_v, "addi_r4_r5");
      if (k == 0) check_lit("t0_after_and", 64'(bus.PCout), 64'd1);
      if (k == 4) check_lit("addi_t4", 64'({bus.Cout, bus.Rout, bus.ALUControl}), 64'({1'b1, 16'h0000, 5'b00011}));
      if (k == 5) check_lit("addi_t5", 64'(bus.Rin), 64'h0010);
      tick();
    end

    // nop then undefined: three cycles each, no register write
    ir_v   = 32'hD0000000;
    bus.IR = ir_v;
    for (int k = 0; k < 3; k++) begin
      cycle(k, ir_v, "nop");
      check_lit("nop_rin", 64'(bus.Rin), 64'd0);
      tick();
    end
    ir_v   = 32'hF8000000;
    bus.IR = ir_v;
    for (int k = 0; k < 3; k++) begin
      cycle(k, ir_v, "undef");
      check_lit("undef_rin", 64'(bus.Rin), 64'd0);
      tick();
    end

    // aliased fields and remaining opcode mix
    run_instr({5'b00100, 4'd0, 4'd0, 4'd0, 15'h0}, 1'b0, "sub_r0_alias");
    run_instr({5'b01011, 4'd15, 4'd14, 4'd13, 15'h7FFF}, 1'b0, "rol_r15");
    run_instr({5'b01110, 4'd9, 4'd3, 4'd0, 15'h00FF}, 1'b0, "ori_r9");
    run_instr({5'b01101, 4'd6, 4'd6, 4'd2, 15'h0}, 1'b0, "andi_r6");
    run_instr({5'b01000, 4'd2, 4'd11, 4'd12, 15'h0}, 1'b0, "shra_r2");

    // Stop high during T3 only is ignored
    ir_v   = {5'b00111, 4'd3, 4'd1, 4'd2, 15'h0};
    bus.IR = ir_v;
    for (int k = 0; k < 6; k++) begin
      bus.Stop = (k == 3);
      cycle(k, ir_v, "shr_stop_t3");
      tick();
    end
    bus.Stop = 1'b0;
    cycle(0, ir_v, "after_stop_t3");
    check_lit("stop_t3_ignored", 64'(bus.Run), 64'd1);

    // Stop at end of T5 halts (continue the T0 already entered)
    tick();
    for (int k = 1; k < 6; k++) begin
      bus.Stop = (k == 5);
      cycle(k, ir_v, "shr_stop_t5");
      tick();
    end
    bus.Stop = 1'b0;
    halted(3, "halt_after_t5_stop");
    check_lit("run_low_after_stop", 64'(bus.Run), 64'd0);

    // halt instruction, then 20 quiet cycles, then reset back to T0
    do_reset(1);
    run_instr(32'hD8000000, 1'b0, "halt_instr");
    for (int i = 0; i < 20; i++) begin
      cycle(-1, 32'h0, "halt_hold");
      if (i == 19) check_lit("halt_hold_run", 64'(bus.Run), 64'd0);
      tick();
    end
    do_reset(1);
    cycle(0, 32'h0, "t0_after_halt_reset");
    check_lit("t0_after_halt_reset_pc", 64'(bus.PCout), 64'd1);
    tick();
    do_reset(1);

    // reset asserted mid-T4 aborts with no register write
    ir_v   = {5'b00011, 4'd5, 4'd6, 4'd7, 15'h0};
    bus.IR = ir_v;
    for (int k = 0; k < 5; k++) begin
      cycle(k, ir_v, "add_abort");
      if (k < 4) tick();
    end
    Reset = 1'b1;
    #1;
    check_lit("abort_clear", 64'(dut_vec()), 64'd0);
    tick();
    do_reset(2);

    // nop with Stop high halts
    run_instr(32'hD0000000, 1'b1, "nop_stop");
    halted(2, "halt_after_nop_stop");

    exp_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
